qspi_word_ctrl: RTL and testbench

//  Sits directly upstream of qspi_controller. Turns 1/2/4-byte CPU read/write requests into byte-serial QSPI transactions.

---
 rtl/qspi_word_ctrl_if.sv | 37 +++
 rtl/qspi_word_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_qspi_word_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/qspi_word_ctrl_if.sv
// rtl/qspi_word_ctrl_if.sv - CPU request and QSPI controller signal bundle for qspi_word_ctrl
interface qspi_word_ctrl_if #(
    parameter int DATA_BYTES = 4
);
    logic [24:0]             addr_in;
    logic [8*DATA_BYTES-1:0] data_in;
    logic [1:0]              data_size;
    logic                    start_read;
    logic                    start_write;
    logic [8*DATA_BYTES-1:0] data_out;
    logic                    done;
    logic                    busy;
    logic [24:0]             q_addr;
    logic [7:0]              q_data_out;
    logic                    q_start_read;
    logic                    q_start_write;
    logic                    q_stall_txn;
    logic                    q_stop_txn;
    logic [7:0]              q_data_in;
    logic                    q_data_req;
    logic                    q_data_ready;
    logic                    q_busy;

    modport slave (
        input  addr_in, data_in, data_size, start_read, start_write,
        input  q_data_in, q_data_req, q_data_ready, q_busy,
        output data_out, done, busy,
        output q_addr, q_data_out, q_start_read, q_start_write, q_stall_txn, q_stop_txn
    );

    modport master (
        output addr_in, data_in, data_size, start_read, start_write,
        output q_data_in, q_data_req, q_data_ready, q_busy,
        input  data_out, done, busy,
        input  q_addr, q_data_out, q_start_read, q_start_write, q_stall_txn, q_stop_txn
    );
endinterface

// File: rtl/qspi_word_ctrl.sv
// rtl/qspi_word_ctrl.sv - word-to-byte QSPI request sequencer; optional QSPI_CONTINUE_EN keeps reads open
module qspi_word_ctrl #(
    parameter int DATA_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    qspi_word_ctrl_if.slave  bus
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int KW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE, START, READ, WRITE, STOP, DROP
`ifdef QSPI_CONTINUE_EN
        , HELD
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   nlast_q, nlast_d;
    logic            is_read_q, is_read_d;
    logic [24:0]     addr_q, addr_d;
    logic [24:0]     next_addr_q, next_addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            done_q, done_d;

    logic            req;
    logic            accept;
    logic            flash_wr;
    logic [KW-1:0]   nlast_in;
    logic [24:0]     nbytes;

    // Request decode: byte count, read priority and the dropped flash-write case
    always_comb begin
        req      = bus.start_read | bus.start_write;
        flash_wr = !bus.start_read && bus.start_write && !bus.addr_in[24];
        case (bus.data_size)
            2'd0:    nlast_in = '0;
            2'd1:    nlast_in = KW'(1);
            default: nlast_in = KW'(DATA_BYTES - 1);
        endcase
        nbytes = 25'(nlast_in) + 25'd1;
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            nlast_q     <= '0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            next_addr_q <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            nlast_q     <= nlast_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic and controller handshake outputs
    always_comb begin
        state_d           = state_q;
        k_d               = k_q;
        nlast_d           = nlast_q;
        is_read_d         = is_read_q;
        addr_d            = addr_q;
        next_addr_d       = next_addr_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        done_d            = 1'b0;
        accept            = 1'b0;
        bus.q_start_read  = 1'b0;
        bus.q_start_write = 1'b0;
        bus.q_stall_txn   = 1'b0;
        bus.q_stop_txn    = 1'b0;
        bus.done          = done_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = flash_wr ? DROP : START;
                end
            end
            START: begin
                // A still-busy controller must not see a start; hold here until it frees up
                if (!bus.q_busy) begin
                    bus.q_start_read  = is_read_q;
                    bus.q_start_write = !is_read_q;
                    state_d           = is_read_q ? READ : WRITE;
                end
            end
            READ: begin
                // Stall ahead of the last byte so the controller pauses once it lands
                bus.q_stall_txn = (k_q == nlast_q);
                if (bus.q_data_ready) begin
                    rdata_d[8*k_q +: 8] = bus.q_data_in;
                    k_d                 = k_q + 1'b1;
                    if (k_q == nlast_q) begin
`ifdef QSPI_CONTINUE_EN
                        state_d = HELD;
                        done_d  = 1'b1;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            WRITE: begin
                if (bus.q_data_req) begin
                    k_d = k_q + 1'b1;
                    if (k_q == nlast_q) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                bus.q_stop_txn = 1'b1;
                bus.done       = 1'b1;
                state_d        = IDLE;
            end
            DROP: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
`ifdef QSPI_CONTINUE_EN
            HELD: begin
                bus.q_stall_txn = 1'b1;
                if (req) begin
                    accept = 1'b1;
                    // Continue only at the exact next address inside the same memory region
                    if (bus.start_read && (bus.addr_in == next_addr_q) &&
                        (bus.addr_in[24:23] == addr_q[24:23])) begin
                        state_d = READ;
                    end else begin
                        bus.q_stop_txn = 1'b1;
                        state_d        = flash_wr ? DROP : START;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (accept) begin
            addr_d      = bus.addr_in;
            wdata_d     = bus.data_in;
            nlast_d     = nlast_in;
            is_read_d   = bus.start_read;
            k_d         = '0;
            next_addr_d = bus.addr_in + nbytes;
            if (bus.start_read) begin
                rdata_d = '0;
            end
        end
    end

    // Registered view of the request towards CPU and controller
    always_comb begin
        bus.data_out   = rdata_q;
        bus.q_addr     = addr_q;
        bus.q_data_out = wdata_q[8*k_q +: 8];
`ifdef QSPI_CONTINUE_EN
        bus.busy       = (state_q != IDLE) && (state_q != HELD);
`else
        bus.busy       = (state_q != IDLE);
`endif
    end
endmodule

// File: tb/tb_qspi_word_ctrl.sv
// tb/tb_qspi_word_ctrl.sv - directed self-checking bench for qspi_word_ctrl
module tb_qspi_word_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n_srd, n_swr, n_stop;
    int   b_srd, b_swr, b_stop;

    qspi_word_ctrl_if #(.DATA_BYTES(4)) bus ();

    qspi_word_ctrl #(.DATA_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            n_srd  <= n_srd  + int'(bus.q_start_read);
            n_swr  <= n_swr  + int'(bus.q_start_write);
            n_stop <= n_stop + int'(bus.q_stop_txn);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic snap();
        b_srd  = n_srd;
        b_swr  = n_swr;
        b_stop = n_stop;
    endtask

    logic [7:0] rd_bytes [4];

    initial begin
        total = 0; bad = 0;
        n_srd = 0; n_swr = 0; n_stop = 0;
        rst = 1'b1;
        bus.addr_in = '0; bus.data_in = '0; bus.data_size = '0;
        bus.start_read = 1'b0; bus.start_write = 1'b0;
        bus.q_data_in = '0; bus.q_data_req = 1'b0; bus.q_data_ready = 1'b0; bus.q_busy = 1'b0;
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;

        smp();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_dout", bus.data_out, 32'd0);
        check("rst_qctl", {bus.q_start_read, bus.q_start_write, bus.q_stall_txn, bus.q_stop_txn, bus.done}, 32'd0);
        check("rst_qaddr", 32'(bus.q_addr), 32'd0);
        step(); step();
        rst = 1'b0;

`ifndef QSPI_CONTINUE_EN
        // 4-byte read from flash, little-endian assembly
        snap();
        step(); bus.addr_in = 25'h0000100; bus.data_size = 2'd2; bus.start_read = 1'b1;
        smp();  check("rd_acc_busy", 32'(bus.busy), 32'd0);
        step(); bus.start_read = 1'b0;
        smp();  check("rd_start", 32'(bus.q_start_read), 32'd1);
                check("rd_qaddr", 32'(bus.q_addr), 32'h100);
                check("rd_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(); bus.q_data_ready = 1'b1; bus.q_data_in = rd_bytes[i];
            smp();  check($sformatf("rd_stall%0d", i), 32'(bus.q_stall_txn), (i == 3) ? 32'd1 : 32'd0);
        end
        step(); bus.q_data_ready = 1'b0;
        smp();  check("rd_stop", 32'(bus.q_stop_txn), 32'd1);
                check("rd_done", 32'(bus.done), 32'd1);
                check("rd_dout", bus.data_out, 32'h44332211);
        step();
        smp();  check("rd_idle", {bus.busy, bus.done, bus.q_stop_txn}, 32'd0);
        check("rd_nstart", 32'(n_srd - b_srd), 32'd1);
        check("rd_nstop", 32'(n_stop - b_stop), 32'd1);

        // 2-byte write to RAM A
        snap();
        step(); bus.addr_in = 25'h1000010; bus.data_in = 32'hA1B2C3D4; bus.data_size = 2'd1; bus.start_write = 1'b1;
        smp();
        step(); bus.start_write = 1'b0;
        smp();  check("wr_start", 32'(bus.q_start_write), 32'd1);
                check("wr_byte0", 32'(bus.q_data_out), 32'hD4);
                check("wr_qaddr", 32'(bus.q_addr), 32'h1000010);
        step(); bus.q_data_req = 1'b1;
        smp();  check("wr_byte0_hold", 32'(bus.q_data_out), 32'hD4);
        step(); bus.q_data_req = 1'b0;
        smp();  check("wr_byte1", 32'(bus.q_data_out), 32'hC3);
                check("wr_nostop", 32'(bus.q_stop_txn), 32'd0);
        step(); bus.q_data_req = 1'b1;
        step(); bus.q_data_req = 1'b0;
        smp();  check("wr_stop", {bus.q_stop_txn, bus.done}, 32'd3);
        step();
        smp();  check("wr_idle", 32'(bus.busy), 32'd0);
        check("wr_nstart", 32'(n_swr - b_swr), 32'd1);

        // Write to flash is dropped
        snap();
        step(); bus.addr_in = 25'h0000020; bus.data_size = 2'd0; bus.start_write = 1'b1;
        smp();
        step(); bus.start_write = 1'b0;
        smp();  check("fw_done", {bus.done, bus.busy, bus.q_start_write, bus.q_stop_txn}, 32'b1100);
        step();
        smp();  check("fw_idle", {bus.done, bus.busy}, 32'd0);
        check("fw_nstart", 32'(n_swr - b_swr), 32'd0);

        // Simultaneous read+write, request while busy, controller busy in START
        snap();
        step(); bus.addr_in = 25'h1000000; bus.data_size = 2'd0; bus.start_read = 1'b1; bus.start_write = 1'b1;
        smp();
        step(); bus.start_read = 1'b0; bus.q_busy = 1'b1;
        smp();  check("both_qbusy_hold", {bus.q_start_read, bus.q_start_write}, 32'd0);
                check("both_busy", 32'(bus.busy), 32'd1);
        step(); bus.q_busy = 1'b0; bus.start_write = 1'b0;
        smp();  check("both_start", {bus.q_start_read, bus.q_start_write}, 32'b10);
        step(); bus.q_data_ready = 1'b1; bus.q_data_in = 8'h5A;
        smp();  check("both_stall_n1", 32'(bus.q_stall_txn), 32'd1);
        step(); bus.q_data_ready = 1'b0;
        smp();  check("both_done", 32'(bus.done), 32'd1);
                check("both_dout", bus.data_out, 32'h0000005A);
        step();
        smp();  check("both_nrd", 32'(n_srd - b_srd), 32'd1);
                check("both_nwr", 32'(n_swr - b_swr), 32'd0);
`else
        // Sequential reads keep the transaction open
        snap();
        step(); bus.addr_in = 25'h1800000; bus.data_size = 2'd2; bus.start_read = 1'b1;
        smp();
        step(); bus.start_read = 1'b0;
        smp();  check("c_start", 32'(bus.q_start_read), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(); bus.q_data_ready = 1'b1; bus.q_data_in = rd_bytes[i];
            smp();
        end
        step(); bus.q_data_ready = 1'b0;
        smp();  check("c_held", {bus.done, bus.q_stall_txn, bus.busy, bus.q_stop_txn}, 32'b1100);
                check("c_dout1", bus.data_out, 32'h44332211);
        step();
        smp();  check("c_held2", {bus.done, bus.q_stall_txn}, 32'b01);
        step(); bus.addr_in = 25'h1800004; bus.data_size = 2'd0; bus.start_read = 1'b1;
        smp();  check("c_seq_nostop", 32'(bus.q_stop_txn), 32'd0);
        step(); bus.start_read = 1'b0;
        smp();  check("c_seq_nostart", 32'(bus.q_start_read), 32'd0);
                check("c_seq_stall", {bus.q_stall_txn, bus.busy}, 32'b11);
        step(); bus.q_data_ready = 1'b1; bus.q_data_in = 8'h99;
        step(); bus.q_data_ready = 1'b0;
        smp();  check("c_seq_done", {bus.done, bus.q_stall_txn}, 32'b11);
                check("c_dout2", bus.data_out, 32'h00000099);
        step(); bus.addr_in = 25'h0000000; bus.data_size = 2'd2; bus.start_read = 1'b1;
        smp();  check("c_jump_stop", 32'(bus.q_stop_txn), 32'd1);
        step(); bus.start_read = 1'b0;
        smp();  check("c_jump_start", {bus.q_start_read, bus.q_stop_txn}, 32'b10);
        step();
        check("c_nstart", 32'(n_srd - b_srd), 32'd2);
        check("c_nstop", 32'(n_stop - b_stop), 32'd1);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
`endif

        // Asynchronous reset in the middle of a read
        step(); bus.addr_in = 25'h0000100; bus.data_size = 2'd1; bus.start_read = 1'b1;
        smp();
        step(); bus.start_read = 1'b0;
        step(); bus.q_data_ready = 1'b1; bus.q_data_in = 8'h77;
        step(); bus.q_data_ready = 1'b0;
        smp();  check("ar_pre_stall", 32'(bus.q_stall_txn), 32'd1);
                check("ar_pre_dout", bus.data_out, 32'h77);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_dout", bus.data_out, 32'd0);
        check("ar_qctl", {bus.q_start_read, bus.q_start_write, bus.q_stall_txn, bus.q_stop_txn, bus.done}, 32'd0);
        check("ar_qaddr", 32'(bus.q_addr), 32'd0);
        check("ar_qdata", 32'(bus.q_data_out), 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
